// File: rtl/muldiv_div_unit.sv
// Iterative RV64M divide/remainder unit (DIV, DIVU, REM, REMU), radix-2 restoring.
// Latency: 66 edges from accept to res_valid for normal ops, 1 edge for div-by-zero / signed overflow.
// Backpressure: one op in flight; start_ready only in IDLE, result held in DONE until res_ready.
module muldiv_div_unit #(
  parameter int XLEN = 64,
  parameter int RDW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RDW-1:0]  rd_in,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [RDW-1:0]  res_rd,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN-1);

  logic [2:0]      state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;     // captured dividend / divisor, kept for sign fix-up
  logic [XLEN-1:0] quo, dvs;     // quotient shift register, divisor magnitude
  logic [XLEN:0]   rem;          // one extra bit so the trial subtract shows its sign
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] res_q;
  logic [RDW-1:0]  rd_q;

  logic            is_signed, is_rem, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [XLEN:0]   shifted, diff;

  // Operand classification, magnitudes, iteration datapath and sign fix-up
  always_comb begin
    is_signed = ~op_q[0];
    is_rem    = op_q[1];
    a_neg     = is_signed & a_q[XLEN-1];
    b_neg     = is_signed & b_q[XLEN-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    div_zero  = (b_q == '0);
    ovf       = is_signed && (a_q == SMIN) && (b_q == ALL_ONES);
    shifted   = {rem[XLEN-1:0], quo[XLEN-1]};
    diff      = shifted - {1'b0, dvs};
    q_fix     = (a_neg ^ b_neg) ? -quo : quo;
    r_fix     = a_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  end

  // Control FSM and datapath registers; flush overrides accept and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      quo   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      res_q <= '0;
      rd_q  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            op_q  <= op;
            a_q   <= rs1_data;
            b_q   <= rs2_data;
            rd_q  <= rd_in;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          if (div_zero) begin
            res_q <= is_rem ? a_q : ALL_ONES;
            state <= S_DONE;
          end else if (ovf) begin
            res_q <= is_rem ? '0 : SMIN;
            state <= S_DONE;
          end else begin
            quo   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!diff[XLEN]) begin
            rem <= diff;
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          res_q <= is_rem ? r_fix : q_fix;
          state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    start_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
    res_valid   = (state == S_DONE);
    res_data    = res_q;
    res_rd      = rd_q;
  end

endmodule
